shared_net_arbiter: RTL and testbench
=====================================

SHARED_NET_ARBITER -- requirements
Module: shared_net_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 Parameter DW, default 8: payload width in bits.
REQ-003 Parameter STAGES, default 2: register stages from grant to output, 1..4; these model the driver flop and the repeater stages on the shared net.
REQ-004 Port ck  input  1: sole clock, rising edge.
REQ-005 Port rn  input  1: asynchronous active-low reset.
REQ-006 Port req  input  NREQ: request per requester; held high until granted.
REQ-007 Port req_data  input  NREQ*DW: payload per requester, slice i = bits [i*DW +: DW]; stable while req[i] is high.
REQ-008 Port gnt  output  NREQ: one-hot, combinational; a transfer occurs in any cycle where req[i] and gnt[i] are both high.
REQ-009 Port out_valid  output  1: last pipeline stage holds valid data.
REQ-010 Port out_data  output  DW: payload of the last stage.
REQ-011 Port out_src  output  3: requester index of the last stage, zero-extended.
REQ-012 Port out_ready  input  1: consumer accepts the output when out_valid and out_ready are both high.
REQ-013 Port busy  output  1: OR of all stage valid bits.
REQ-014 Port xfer_count  output  16: count of output handshakes, saturating.

Function
REQ-015 Stall condition: stall = out_valid && !out_ready.
- When stall is low, all stages advance by one position.
- When stall is high, all stages hold.
REQ-016 gnt is all-zero when stall is high.
REQ-017 When stall is low and at least one req bit is high, gnt selects exactly one requester by round-robin order.
REQ-018 Round-robin pointer ptr:
- The search starts at index ptr and wraps past NREQ-1 to 0.
- After a grant to index i, ptr becomes (i+1) mod NREQ.
- When there is no grant, ptr holds.
REQ-019 Stage 0 load on a non-stalled edge:
- With a grant: stage 0 captures {valid=1, data=req_data slice, src=index}.
- Without a grant: stage 0 captures valid=0, and its data and src hold.
REQ-020 Latency: a grant in cycle t produces out_valid=1 with that payload in cycle t+STAGES, provided no stall occurs in between; each stall cycle adds exactly one cycle.
REQ-021 Throughput is one grant per cycle when out_ready is held high; there are no bubbles between back-to-back grants.
REQ-022 A stall never drops, duplicates or reorders an accepted payload.
REQ-023 xfer_count increments on each out_valid && out_ready cycle and saturates at 16'hFFFF.
REQ-024 Edge cases:
- A requester that deasserts req without having been granted is simply dropped, with no side effect.
- With a single requester active, that requester is granted every non-stalled cycle.

Reset
REQ-025 While rn is low, asynchronously:
- all stage valid bits = 0, data = 0, src = 0;
- ptr = 0;
- xfer_count = 0.
REQ-026 Output values during reset: out_valid=0, out_data=0, out_src=0, busy=0, xfer_count=0.
REQ-027 gnt is 0 while rn is low.
REQ-028 Reset asserted mid-transfer discards all in-flight payloads; there is no partial output after release.
REQ-029 Operation restarts with ptr=0 on the first rising edge after rn deasserts.

Structure
REQ-030 A package shared_net_pkg holds:
- constants SRC_W=3 and CNT_W=16;
- a packed struct stage_t {valid, src, data} with parameterized width via DW localparam usage in the module.
REQ-031 The round-robin search and its pointer live in one sub-module, rr_arbiter, with ports ck, rn, req, en, gnt.
- en is the inverse of stall.
- rr_arbiter holds ptr.
REQ-032 The pipeline is a generate loop over STAGES instances of stage_t registers; there is no other sub-module.

Verification
REQ-033 Reset: hold rn=0 with req=4'b1111 -> gnt=0, out_valid=0, xfer_count=0; after release, the first grant goes to index 0.
REQ-034 Round-robin: STAGES=2, out_ready=1, req=4'b1111 held, data_i=8'h10+i -> gnt sequence 0,1,2,3,0; out_data 8'h10,8'h11,8'h12,8'h13 appears from cycle 2 onward; out_src matches the grant order.
REQ-035 Stall: after 3 grants, drop out_ready for 4 cycles -> gnt=0 and outputs frozen throughout; on release, payloads resume in order with none lost or duplicated.
REQ-036 Sparse requests: req=4'b0100 only -> gnt=4'b0100 every cycle; then assert req=4'b0101 with ptr=3 -> index 0 is granted first.
REQ-037 Reset mid-flight: assert rn low while busy=1 -> out_valid drops immediately, asynchronously, and nothing stale appears after release.
REQ-038 Counter saturation: force 65540 handshakes -> xfer_count stops at 16'hFFFF.

Source files
------------

// File: rtl/shared_net_pkg.sv
// Shared constants and helpers for the shared-net arbiter slice.
package shared_net_pkg;

  localparam int unsigned SRC_W = 3;
  localparam int unsigned CNT_W = 16;

  // Index of the set bit in a one-hot vector (zero when no bit is set).
  function automatic logic [SRC_W-1:0] onehot_idx(input logic [7:0] oh);
    logic [SRC_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[i]) idx = i[SRC_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, search starts at ptr.
module rr_arbiter
  import shared_net_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic            ck,
  input  logic            rn,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt
);

  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] ptr_nxt;
  logic             found;

  // First requester at or after ptr (wrapping) wins; ptr moves past it.
  // Offset k is the outer loop so every index select uses a loop constant.
  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    if (rn && en) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (!found && req[i] && (((32'(ptr) + k) % NREQ) == i)) begin
            found   = 1'b1;
            gnt[i]  = 1'b1;
            ptr_nxt = SRC_W'((i + 1) % NREQ);
          end
        end
      end
    end
  end

  // Pointer register; holds when nothing is granted.
  always_ff @(posedge ck or negedge rn) begin
    if (!rn) ptr <= '0;
    else     ptr <= ptr_nxt;
  end

endmodule

// File: rtl/shared_net_arbiter.sv
// Arbitrated driver onto a shared net with a stallable repeater pipeline.
module shared_net_arbiter
  import shared_net_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DW     = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic               ck,
  input  logic               rn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic [SRC_W-1:0]   out_src,
  input  logic               out_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   xfer_count
);

  typedef struct packed {
    logic             valid;
    logic [SRC_W-1:0] src;
    logic [DW-1:0]    data;
  } stage_t;

  logic             stall;
  logic [SRC_W-1:0] gnt_idx;
  logic [DW-1:0]    gnt_data;
  logic [STAGES-1:0] vld;
  stage_t           last;

  assign stall = out_valid && !out_ready;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .ck  (ck),
    .rn  (rn),
    .req (req),
    .en  (!stall),
    .gnt (gnt)
  );

  assign gnt_idx = onehot_idx(8'(gnt));

  // Payload mux for the granted requester.
  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) gnt_data = req_data[i*DW +: DW];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    stage_t q;
    if (g == 0) begin : g_head
      // Driver flop: captures the grant; data/src hold on an empty slot.
      always_ff @(posedge ck or negedge rn) begin
        if (!rn) begin
          q <= '0;
        end else if (!stall) begin
          q.valid <= |gnt;
          if (|gnt) begin
            q.src  <= gnt_idx;
            q.data <= gnt_data;
          end
        end
      end
    end else begin : g_tail
      // Repeater stage: advances together with the whole pipe.
      always_ff @(posedge ck or negedge rn) begin
        if (!rn)         q <= '0;
        else if (!stall) q <= g_stage[g-1].q;
      end
    end
    assign vld[g] = q.valid;
  end

  assign last      = g_stage[STAGES-1].q;
  assign out_valid = last.valid;
  assign out_data  = last.data;
  assign out_src   = last.src;
  assign busy      = |vld;

  // Saturating handshake counter.
  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      xfer_count <= '0;
    end else if (out_valid && out_ready && (xfer_count != '1)) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_shared_net_arbiter.sv
// Directed bench for shared_net_arbiter (NREQ=4, DW=8, STAGES=2).
module tb_shared_net_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned DW     = 8;
  localparam int unsigned STAGES = 2;

  logic                ck = 1'b0;
  logic                rn = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*DW-1:0]  req_data = '0;
  logic [NREQ-1:0]     gnt;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic [2:0]          out_src;
  logic                out_ready = 1'b1;
  logic                busy;
  logic [15:0]         xfer_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  shared_net_arbiter #(.NREQ(NREQ), .DW(DW), .STAGES(STAGES)) dut (
    .ck         (ck),
    .rn         (rn),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .busy       (busy),
    .xfer_count (xfer_count)
  );

  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge ck);
    #1;
  endtask

  task automatic do_reset;
    rn = 1'b0;
    tick;
    tick;
    rn = 1'b1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 8'h10 + 8'(i);

    // Reset held with all requesters active
    req = 4'b1111;
    rn  = 1'b0;
    tick;
    tick;
    check("rst_gnt",   32'(gnt),        0);
    check("rst_valid", 32'(out_valid),  0);
    check("rst_cnt",   32'(xfer_count), 0);
    check("rst_busy",  32'(busy),       0);
    check("rst_data",  32'(out_data),   0);
    check("rst_src",   32'(out_src),    0);

    // Round-robin with full throughput
    rn = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      check("rr_gnt", 32'(gnt), 32'(1) << (k % 4));
      if (k >= 2) begin
        check("rr_valid", 32'(out_valid), 1);
        check("rr_data",  32'(out_data),  32'h10 + 32'((k - 2) % 4));
        check("rr_src",   32'(out_src),   32'((k - 2) % 4));
        check("rr_cnt",   32'(xfer_count), 32'(k - 2));
      end else begin
        check("rr_valid", 32'(out_valid), 0);
        check("rr_cnt",   32'(xfer_count), 0);
      end
      tick;
    end

    // Stall after three grants
    do_reset;
    check("st_g0", 32'(gnt), 32'h1);
    tick;
    check("st_g1", 32'(gnt), 32'h2);
    tick;
    check("st_g2", 32'(gnt), 32'h4);
    check("st_d0", 32'(out_data), 32'h10);
    tick;
    out_ready = 1'b0;
    #1;
    for (int s = 0; s < 4; s++) begin
      check("st_hold_gnt",   32'(gnt),        0);
      check("st_hold_valid", 32'(out_valid),  1);
      check("st_hold_data",  32'(out_data),   32'h11);
      check("st_hold_src",   32'(out_src),    1);
      check("st_hold_cnt",   32'(xfer_count), 1);
      tick;
    end
    out_ready = 1'b1;
    #1;
    begin
      logic [3:0] eg [4];
      logic [7:0] ed [4];
      logic [2:0] es [4];
      eg = '{4'h8, 4'h1, 4'h2, 4'h4};
      ed = '{8'h11, 8'h12, 8'h13, 8'h10};
      es = '{3'd1, 3'd2, 3'd3, 3'd0};
      for (int r = 0; r < 4; r++) begin
        check("st_rel_gnt",  32'(gnt),      32'(eg[r]));
        check("st_rel_data", 32'(out_data), 32'(ed[r]));
        check("st_rel_src",  32'(out_src),  32'(es[r]));
        tick;
      end
    end
    check("st_cnt", 32'(xfer_count), 5);

    // Sparse requests: single requester, then wrap from ptr=3
    do_reset;
    req = 4'b0100;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("sp_gnt", 32'(gnt), 32'h4);
      if (k >= 2) begin
        check("sp_src",  32'(out_src),  2);
        check("sp_data", 32'(out_data), 32'h12);
      end
      tick;
    end
    req = 4'b0101;
    #1;
    check("sp_wrap_gnt", 32'(gnt), 32'h1);
    tick;
    check("sp_next_gnt", 32'(gnt), 32'h4);
    tick;
    check("sp_out_src",  32'(out_src),  0);
    check("sp_out_data", 32'(out_data), 32'h10);
    check("sp_busy",     32'(busy),     1);

    // Asynchronous reset mid-flight
    #2;
    rn = 1'b0;
    #1;
    check("mf_valid", 32'(out_valid),  0);
    check("mf_busy",  32'(busy),       0);
    check("mf_gnt",   32'(gnt),        0);
    check("mf_data",  32'(out_data),   0);
    check("mf_cnt",   32'(xfer_count), 0);
    req = 4'b0000;
    tick;
    tick;
    rn = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("mf_post_valid", 32'(out_valid), 0);
      check("mf_post_busy",  32'(busy),      0);
      tick;
    end
    req = 4'b1111;
    #1;
    check("mf_first_gnt", 32'(gnt), 32'h1);

    // Counter saturation
    do_reset;
    req = 4'b1111;
    out_ready = 1'b1;
    #1;
    repeat (65536) tick;
    check("sat_pre",  32'(xfer_count), 32'hFFFE);
    tick;
    check("sat_max",  32'(xfer_count), 32'hFFFF);
    repeat (5) tick;
    check("sat_hold", 32'(xfer_count), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
